// File: rtl/onehot_grant_decoder_pkg.sv
// Shared definitions for the request/grant path (priority encoder and grant decoder).
// Contents:
//   IDX_W_DEF / N_DEF : default encoded-index width and one-hot width
//   state_t           : grant decoder FSM state encoding
package onehot_grant_decoder_pkg;

  localparam int unsigned IDX_W_DEF = 3;
  localparam int unsigned N_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_grant_decoder_dec.sv
// onehot_dec: combinational IDX_W -> N one-hot decoder.
// Ports:
//   idx    in  IDX_W  encoded index
//   onehot out N      onehot[idx] = 1, all other bits 0
module onehot_dec
  import onehot_grant_decoder_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned N     = N_DEF
) (
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_grant_decoder.sv
// onehot_grant_decoder: registered index -> one-hot grant with fixed hold time.
// An accepted index drives grant[idx] for HOLD_CYCLES cycles, followed by a
// one-cycle GAP where done pulses. en low during GRANT aborts without done.
// Optional feature macro: GRANT_CNT_EN adds a saturating completed-grant counter.
// Ports:
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous active-high reset
//   en        in   1      enable; low ignores new indices and aborts a grant
//   Y         in   IDX_W  encoded index
//   valid     in   1      Y is meaningful
//   ready     out  1      high in IDLE
//   grant     out  N      registered one-hot grant
//   busy      out  1      high in GRANT or GAP
//   done      out  1      one-cycle pulse in GAP
//   grant_cnt out  CNT_W  completed-grant count (GRANT_CNT_EN only)
module onehot_grant_decoder
  import onehot_grant_decoder_pkg::*;
#(
  parameter int unsigned IDX_W       = IDX_W_DEF,
  parameter int unsigned N           = N_DEF,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IDX_W-1:0] Y,
  input  logic             valid,
  output logic             ready,
  output logic [N-1:0]     grant,
  output logic             busy,
  output logic             done
`ifdef GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0] grant_cnt
`endif
);

  if (N != (1 << IDX_W) || HOLD_CYCLES == 0 || HOLD_CYCLES > 255 || CNT_W == 0) begin : g_param_check
    $fatal(1, "onehot_grant_decoder: illegal parameters (need N==2**IDX_W, 1<=HOLD_CYCLES<=255)");
  end

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_V = HW'(HOLD_CYCLES);

  state_t           state, state_n;
  logic             accept;
  logic [HW-1:0]    hold_cnt;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [N-1:0]     dec;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (valid && en) begin
          state_n = GRANT;
          accept  = 1'b1;
        end
      end
      GRANT: begin
        if (!en)                     state_n = IDLE;
        else if (hold_cnt == HOLD_V) state_n = GAP;
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign idx_n = accept ? Y : idx_q;

  onehot_dec #(.IDX_W(IDX_W), .N(N)) u_dec (
    .idx    (idx_n),
    .onehot (dec)
  );

  // grant is registered from the next-state decode so it changes only on the clock
  // edge and lines up with the state register (no combinational glitching).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      idx_q    <= '0;
      grant    <= '0;
    end else begin
      state <= state_n;
      idx_q <= idx_n;
      grant <= (state_n == GRANT) ? dec : '0;
      if (accept)
        hold_cnt <= HW'(1);
      else if (state == GRANT && state_n == GRANT)
        hold_cnt <= hold_cnt + HW'(1);
      else if (state_n != GRANT)
        hold_cnt <= '0;
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == GRANT) || (state == GAP);
  assign done  = (state == GAP);

`ifdef GRANT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      grant_cnt <= '0;
    else if (done && grant_cnt != '1)
      grant_cnt <= grant_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_onehot_grant_decoder.sv
module tb_onehot_grant_decoder;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] Y = '0;
  logic       valid = 1'b0;
  logic       ready;
  logic [7:0] grant;
  logic       busy;
  logic       done;
`ifdef GRANT_CNT_EN
  logic [7:0] grant_cnt;
`endif

  onehot_grant_decoder #(.IDX_W(3), .N(8), .HOLD_CYCLES(H), .CNT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .Y     (Y),
    .valid (valid),
    .ready (ready),
    .grant (grant),
    .busy  (busy),
    .done  (done)
`ifdef GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: time-window view. acc = cycle index of the first grant cycle
  // of the current transaction (-1 when none). ec = cycles elapsed (edges seen).
  int ec = 0;
  int acc = -1;
  int m_idx = 0;
  int m_cnt = 0;

  function automatic int phase();
    return (acc < 0) ? -1 : ec - acc;
  endfunction

  function automatic bit m_idle();
    int p = phase();
    return (p < 0) || (p > H);
  endfunction

  // {grant, busy, done, ready}
  function automatic logic [10:0] exp_vec();
    int p = phase();
    logic [7:0] g;
    logic b;
    g = (p >= 0 && p < H) ? 8'(1 << m_idx) : 8'h00;
    b = (p >= 0 && p <= H);
    return {g, b, (p == H), !b};
  endfunction

  task automatic tick(input logic r, input logic e, input logic v, input logic [2:0] y);
    int p;
    rst = r; en = e; valid = v; Y = y;
    @(posedge clk);
    if (r) begin
      acc = -1;
      m_cnt = 0;
    end else begin
      p = phase();
      if (m_idle()) begin
        acc = -1;
        if (v && e) begin
          acc = ec + 1;
          m_idx = int'(y);
        end
      end else if (p < H) begin
        if (!e) acc = -1;
      end else begin
        if (m_cnt < 255) m_cnt++;
      end
    end
    ec++;
    #1;
  endtask

  logic [10:0] obs, exp_v;

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick((i < 2), 1'b0, 1'b0, 3'd0);
      obs = {grant, busy, done, ready}; exp_v = exp_vec(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", ec, obs, exp_v); end
      total++;
      if (exp_v !== 11'b00000000_001) begin bad++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", ec, exp_v, 11'h001); end
`ifdef GRANT_CNT_EN
      total++;
      if (grant_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", grant_cnt); end
`endif
    end
  endtask

  task automatic test_single();
    int gcycles = 0;
    int dcycles = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, (i == 0), (i == 0) ? 3'd5 : 3'($urandom_range(7)));
      if (grant == 8'b0010_0000) gcycles++;
      if (done) dcycles++;
      obs = {grant, busy, done, ready}; exp_v = exp_vec(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL single cyc=%0d got=%h exp=%h", ec, obs, exp_v); end
    end
    total++;
    if (gcycles != H) begin bad++; $display("FAIL single_len got=%0d exp=%0d", gcycles, H); end
    total++;
    if (dcycles != 1) begin bad++; $display("FAIL single_done got=%0d exp=1", dcycles); end
  endtask

  task automatic test_back_to_back();
    int last_rise = -1;
    logic [7:0] prev_g = '0;
    int start_cnt = m_cnt;
    for (int i = 0; i < 8; i++) begin
      bit got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        if (m_idle()) got = 1;
        tick(1'b0, 1'b1, 1'b1, 3'(i));
        obs = {grant, busy, done, ready}; exp_v = exp_vec(); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL walk y=%0d cyc=%0d got=%h exp=%h", i, ec, obs, exp_v); end
        if (grant != 8'h00 && prev_g == 8'h00) begin
          if (last_rise >= 0) begin
            total++;
            if (ec - last_rise != H + 2) begin bad++; $display("FAIL walk_spacing got=%0d exp=%0d", ec - last_rise, H + 2); end
          end
          last_rise = ec;
        end
        prev_g = grant;
      end
      if (!got) begin total++; bad++; $display("FAIL walk_timeout y=%0d got=busy exp=accept", i); end
    end
    for (int k = 0; k < H + 2; k++) begin
      tick(1'b0, 1'b1, 1'b0, 3'd0);
      obs = {grant, busy, done, ready}; exp_v = exp_vec(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL walk_tail cyc=%0d got=%h exp=%h", ec, obs, exp_v); end
    end
    total++;
    if (m_cnt - start_cnt != 8) begin bad++; $display("FAIL walk_count got=%0d exp=8", m_cnt - start_cnt); end
`ifdef GRANT_CNT_EN
    total++;
    if (int'(grant_cnt) != m_cnt) begin bad++; $display("FAIL walk_cnt got=%0d exp=%0d", grant_cnt, m_cnt); end
`endif
  endtask

  task automatic test_abort();
    int dseen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, (i != 2), (i == 0), 3'd2);
      if (done) dseen++;
      obs = {grant, busy, done, ready}; exp_v = exp_vec(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL abort cyc=%0d got=%h exp=%h", ec, obs, exp_v); end
      if (i == 2) begin
        total++;
        if (grant !== 8'h00 || ready !== 1'b1) begin bad++; $display("FAIL abort_idle got=%h/%b exp=00/1", grant, ready); end
      end
    end
    total++;
    if (dseen != 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", dseen); end
`ifdef GRANT_CNT_EN
    total++;
    if (int'(grant_cnt) != m_cnt) begin bad++; $display("FAIL abort_cnt got=%0d exp=%0d", grant_cnt, m_cnt); end
`endif
  endtask

  task automatic test_ignore();
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b1, (i <= H), (i == 0) ? 3'd7 : 3'd1);
      obs = {grant, busy, done, ready}; exp_v = exp_vec(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL ignore cyc=%0d got=%h exp=%h", ec, obs, exp_v); end
      total++;
      if (grant !== 8'h00 && grant !== 8'h80) begin bad++; $display("FAIL ignore_bit got=%h exp=80_or_00", grant); end
    end
  endtask

  task automatic test_midreset();
    int dseen = 0;
    for (int i = 0; i < 8; i++) begin
      tick((i == 2), 1'b1, (i == 0), 3'd4);
      if (done) dseen++;
      obs = {grant, busy, done, ready}; exp_v = exp_vec(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL midreset cyc=%0d got=%h exp=%h", ec, obs, exp_v); end
    end
    total++;
    if (dseen != 0) begin bad++; $display("FAIL midreset_done got=%0d exp=0", dseen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(49) == 0), ($urandom_range(7) != 0), $urandom_range(1) == 1, 3'($urandom_range(7)));
      obs = {grant, busy, done, ready}; exp_v = exp_vec(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", ec, obs, exp_v); end
`ifdef GRANT_CNT_EN
      total++;
      if (int'(grant_cnt) != m_cnt) begin bad++; $display("FAIL random_cnt cyc=%0d got=%0d exp=%0d", ec, grant_cnt, m_cnt); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_ignore();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
